// File: rtl/vga_write_buffer.sv
// vga_write_buffer: FIFO between the memory stage and the framebuffer write port.
// It queues pixel writes and drains them only while drain_ok is high.
//
// Ports:
//   clock, reset (async, active-high)
//   vga_wren_enable / vga_data_addr / vga_data_write : pixel write request
//   drain_ok : the framebuffer port may be written this cycle
//   fb_wren / fb_addr / fb_data : registered framebuffer write port
//   full / empty / count : occupancy; full is the processor stall source
//   overflow : sticky flag, set when a request is dropped while full
//
// Optional build macro VGA_COALESCE_EN:
//   A write to the same address as the newest queued entry overwrites
//   that entry's colour. It does not take a new slot.
module vga_write_buffer #(
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              vga_wren_enable,
  input  logic [ADDR_W-1:0] vga_data_addr,
  input  logic [DATA_W-1:0] vga_data_write,
  input  logic              drain_ok,
  output logic              fb_wren,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_data,
  output logic              full,
  output logic              empty,
  output logic [PTR_W:0]    count,
  output logic              overflow
);

  localparam logic [PTR_W:0]   LP_FULL    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   LP_CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] LP_PTR_ONE = PTR_W'(1);

  logic [ADDR_W-1:0] r_mem_addr [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              r_overflow;
  logic              r_fb_wren;
  logic [ADDR_W-1:0] r_fb_addr;
  logic [DATA_W-1:0] r_fb_data;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_merge;

  // Flags come from the occupancy counter. When the FIFO is full,
  // the two pointers are equal, so pointer equality alone cannot
  // tell full from empty.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == LP_FULL);
  assign w_pop   = drain_ok & ~w_empty;

`ifdef VGA_COALESCE_EN
  logic [PTR_W-1:0] w_last_ptr;

  assign w_last_ptr = r_wr_ptr - LP_PTR_ONE;

  // Do not merge into the only entry while that entry is leaving.
  // The merged colour would otherwise be lost.
  assign w_merge = vga_wren_enable & ~w_empty
                 & (r_mem_addr[w_last_ptr] == vga_data_addr)
                 & ~((r_count == LP_CNT_ONE) & w_pop);
`else
  assign w_merge = 1'b0;
`endif

  // A request while full is still accepted if a slot frees this cycle.
  assign w_push = vga_wren_enable & ~w_merge & (~w_full | w_pop);
  assign w_drop = vga_wren_enable & ~w_merge & w_full & ~w_pop;

  // Storage has no reset. Only entries inside the pointer window are read.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= vga_data_addr;
      r_mem_data[r_wr_ptr] <= vga_data_write;
    end
`ifdef VGA_COALESCE_EN
    else if (w_merge) begin
      r_mem_data[w_last_ptr] <= vga_data_write;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_fb_wren  <= 1'b0;
      r_fb_addr  <= '0;
      r_fb_data  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      end

      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LP_CNT_ONE;
        2'b01:   r_count <= r_count - LP_CNT_ONE;
        default: r_count <= r_count;
      endcase

      if (w_drop) begin
        r_overflow <= 1'b1;
      end

      // When there is no pop, the address and data keep their last
      // values and only the strobe drops.
      r_fb_wren <= w_pop;
      if (w_pop) begin
        r_fb_addr <= r_mem_addr[r_rd_ptr];
        r_fb_data <= r_mem_data[r_rd_ptr];
      end
    end
  end

  assign fb_wren  = r_fb_wren;
  assign fb_addr  = r_fb_addr;
  assign fb_data  = r_fb_data;
  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_vga_write_buffer.sv
// tb_vga_write_buffer: directed, self-checking bench for vga_write_buffer.
// It uses a vector table plus sequences for fill, wrap, reset and coalescing.
module tb_vga_write_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        vga_wren_enable = 1'b0;
  logic [18:0] vga_data_addr = '0;
  logic [7:0]  vga_data_write = '0;
  logic        drain_ok = 1'b0;
  logic        fb_wren;
  logic [18:0] fb_addr;
  logic [7:0]  fb_data;
  logic        full;
  logic        empty;
  logic [4:0]  count;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;

  vga_write_buffer #(
    .DEPTH (16),
    .PTR_W (4),
    .ADDR_W(19),
    .DATA_W(8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .vga_wren_enable(vga_wren_enable),
    .vga_data_addr  (vga_data_addr),
    .vga_data_write (vga_data_write),
    .drain_ok       (drain_ok),
    .fb_wren        (fb_wren),
    .fb_addr        (fb_addr),
    .fb_data        (fb_data),
    .full           (full),
    .empty          (empty),
    .count          (count),
    .overflow       (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic [18:0] addr;
    logic [7:0]  data;
    logic        drain;
    logic        e_wren;
    logic [18:0] e_addr;
    logic [7:0]  e_data;
    logic [4:0]  e_cnt;
    logic        e_full;
    logic        e_empty;
    logic        e_ovf;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    vga_wren_enable = 1'b0;
    drain_ok = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic wr(input logic [18:0] a, input logic [7:0] d);
    vga_wren_enable = 1'b1;
    vga_data_addr = a;
    vga_data_write = d;
    step();
    vga_wren_enable = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    int emit;
    logic [26:0] last;
    logic [26:0] expq[$];
    logic [4:0] exp_c3;

    vt[0] = '{1'b1, 19'h00123, 8'h3C, 1'b1,
              1'b0, 19'h0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b0, 19'h0, 8'h00, 1'b1,
              1'b1, 19'h00123, 8'h3C, 5'd0, 1'b0, 1'b1, 1'b0};
    vt[2] = '{1'b0, 19'h0, 8'h00, 1'b1,
              1'b0, 19'h00123, 8'h3C, 5'd0, 1'b0, 1'b1, 1'b0};
    vt[3] = '{1'b1, 19'h00200, 8'h11, 1'b0,
              1'b0, 19'h00123, 8'h3C, 5'd1, 1'b0, 1'b0, 1'b0};
    vt[4] = '{1'b1, 19'h00201, 8'h22, 1'b0,
              1'b0, 19'h00123, 8'h3C, 5'd2, 1'b0, 1'b0, 1'b0};
    vt[5] = '{1'b1, 19'h00202, 8'h33, 1'b1,
              1'b1, 19'h00200, 8'h11, 5'd2, 1'b0, 1'b0, 1'b0};
    vt[6] = '{1'b0, 19'h0, 8'h00, 1'b1,
              1'b1, 19'h00201, 8'h22, 5'd1, 1'b0, 1'b0, 1'b0};
    vt[7] = '{1'b0, 19'h0, 8'h00, 1'b0,
              1'b0, 19'h00201, 8'h22, 5'd1, 1'b0, 1'b0, 1'b0};
    vt[8] = '{1'b0, 19'h0, 8'h00, 1'b1,
              1'b1, 19'h00202, 8'h33, 5'd0, 1'b0, 1'b1, 1'b0};
    vt[9] = '{1'b0, 19'h0, 8'h00, 1'b1,
              1'b0, 19'h00202, 8'h33, 5'd0, 1'b0, 1'b1, 1'b0};

    #1;
    chk("reset_state", {fb_wren, fb_addr, fb_data, count, full, empty,
                        overflow},
        {1'b0, 19'h0, 8'h0, 5'd0, 1'b0, 1'b1, 1'b0});
    do_reset();

    // Table: latency, push+pop, gated drain, and hold behaviour.
    for (int i = 0; i < 10; i++) begin
      vga_wren_enable = vt[i].wr;
      vga_data_addr   = vt[i].addr;
      vga_data_write  = vt[i].data;
      drain_ok        = vt[i].drain;
      step();
      chk($sformatf("vec%0d", i),
          {fb_wren, fb_addr, fb_data, count, full, empty, overflow},
          {vt[i].e_wren, vt[i].e_addr, vt[i].e_data, vt[i].e_cnt,
           vt[i].e_full, vt[i].e_empty, vt[i].e_ovf});
    end
    vga_wren_enable = 1'b0;

    // Fill and overflow.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      wr(19'(i), 8'(i + 8'h40));
      if (i == 15) begin
        chk("fill16_full", {full, count, overflow},
            {1'b1, 5'd16, 1'b0});
      end
    end
    chk("fill17_drop", {full, count, overflow}, {1'b1, 5'd16, 1'b1});
    drain_ok = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      chk($sformatf("drain_order%0d", k), {fb_wren, fb_addr, fb_data},
          {1'b1, 19'(k), 8'(k + 8'h40)});
    end
    step();
    chk("drain_done", {fb_wren, empty, overflow}, {1'b0, 1'b1, 1'b1});

    // Asynchronous reset while entries are queued.
    drain_ok = 1'b0;
    for (int i = 0; i < 6; i++) wr(19'h00300 + 19'(i), 8'(i));
    drain_ok = 1'b1;
    step();
    drain_ok = 1'b0;
    chk("pre_reset", {count, fb_wren, overflow}, {5'd5, 1'b1, 1'b1});
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset", {count, empty, full, fb_wren, overflow, fb_addr},
        {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 19'h0});
    step();
    reset = 1'b0;

    // Full with simultaneous push and pop.
    for (int i = 0; i < 16; i++) wr(19'h00100 + 19'(i), 8'(i));
    chk("full_pre", {count, overflow}, {5'd16, 1'b0});
    vga_wren_enable = 1'b1;
    vga_data_addr = 19'h7FFFF;
    vga_data_write = 8'hEE;
    drain_ok = 1'b1;
    step();
    vga_wren_enable = 1'b0;
    chk("full_pushpop", {count, overflow, fb_wren, fb_addr},
        {5'd16, 1'b0, 1'b1, 19'h00100});
    emit = 0;
    last = '0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (fb_wren) begin
        emit++;
        last = {fb_addr, fb_data};
      end
    end
    chk("full_emit_cnt", 64'(emit), 64'd16);
    chk("full_emit_last", 64'(last), {37'd0, 19'h7FFFF, 8'hEE});

    // Gated drain, stalls on full, and pointer wrap.
    do_reset();
    begin
      int sent;
      int got;
      int cyc;
      logic [26:0] w;
      sent = 0;
      got = 0;
      cyc = 0;
      expq.delete();
      while (got < 40 && cyc < 2000) begin
        drain_ok = ((cyc / 3) % 2) == 0;
        if (sent < 40 && !full) begin
          vga_wren_enable = 1'b1;
          vga_data_addr = 19'h01000 + 19'(sent);
          vga_data_write = 8'(sent) ^ 8'hA5;
          expq.push_back({vga_data_addr, vga_data_write});
          sent++;
        end else begin
          vga_wren_enable = 1'b0;
        end
        step();
        if (fb_wren) begin
          if (!drain_ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL gate_prev_drain: fb_wren=1 expected 0");
          end
          if (expq.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL gate_extra: got %0h expected none",
                     {fb_addr, fb_data});
          end else begin
            w = expq.pop_front();
            chk($sformatf("gate_order%0d", got), {fb_addr, fb_data}, w);
          end
          got++;
        end
        cyc++;
      end
      vga_wren_enable = 1'b0;
      chk("gate_total", 64'(got), 64'd40);
      chk("gate_sent", 64'(sent), 64'd40);
      chk("gate_final", {empty, overflow}, {1'b1, 1'b0});
    end

    // Same-address writes: merged with the macro, separate without it.
    do_reset();
    wr(19'h00010, 8'h01);
    wr(19'h00010, 8'h02);
    wr(19'h00011, 8'h03);
    expq.delete();
`ifdef VGA_COALESCE_EN
    exp_c3 = 5'd2;
`else
    exp_c3 = 5'd3;
    expq.push_back({19'h00010, 8'h01});
`endif
    expq.push_back({19'h00010, 8'h02});
    expq.push_back({19'h00011, 8'h03});
    chk("same_addr_count", {count, overflow}, {exp_c3, 1'b0});
    drain_ok = 1'b1;
    emit = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (fb_wren) begin
        if (expq.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL same_addr_extra: got %0h expected none",
                   {fb_addr, fb_data});
        end else begin
          chk($sformatf("same_addr%0d", emit), {fb_addr, fb_data},
              expq.pop_front());
        end
        emit++;
      end
    end
    chk("same_addr_left", 64'(expq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
